// File: rtl/lmt_match_aggregator_pkg.sv
`timescale 1ns/1ps
// Shared rmt geometry package: gear encodings, width/depth decode and the
// PMT index of a (depth, width) segment. Also used by pmt_manager and
// segment_crossbar.
package lmt_match_aggregator_pkg;

    typedef enum logic [1:0] {
        WG_X1  = 2'b00,
        WG_X2  = 2'b01,
        WG_X4  = 2'b10,
        WG_BAD = 2'b11
    } width_gear_e;

    localparam logic [2:0] DG_MAX           = 3'd3;
    localparam int         MAX_PMTS_PER_LMT = 8;

    // PMTs side by side; the illegal gear decodes as 4 and is flagged separately
    function automatic int gear_wn(input logic [1:0] g);
        case (g)
            WG_X1:   return 1;
            WG_X2:   return 2;
            WG_X4:   return 4;
            default: return 4;
        endcase
    endfunction

    // PMTs stacked in depth
    function automatic int gear_dn(input logic [2:0] g);
        return int'(32'd1 << g);
    endfunction

    // physical table serving segment (d, w)
    function automatic int pmt_index(input int aspid, input int wn, input int d, input int w);
        return aspid + d * wn + w;
    endfunction

endpackage

// File: rtl/lmt_prio_encoder.sv
`timescale 1ns/1ps
// Lowest-index priority encoder over one LMT's combined matchlines.
module lmt_prio_encoder #(
    parameter int LMT_MAX_DEPTH  = 256,
    parameter int LMT_ADDR_WIDTH = 8
) (
    input  logic [LMT_MAX_DEPTH-1:0]  lines,
    output logic [LMT_ADDR_WIDTH-1:0] addr,
    output logic                      found
);

    // scan downwards so the lowest set row is the last one written
    always_comb begin
        found = 1'b0;
        addr  = '0;
        for (int r = LMT_MAX_DEPTH - 1; r >= 0; r--) begin
            if (lines[r]) begin
                found = 1'b1;
                addr  = LMT_ADDR_WIDTH'(r);
            end
        end
    end

endmodule

// File: rtl/lmt_match_aggregator.sv
`timescale 1ns/1ps
// Builds each logical match table's matchlines from the physical pool
// (AND across width, concatenate across depth), then runs a two-stage
// pipeline: stage 1 registers the combined lines, stage 2 registers the
// priority encode, the result strobe and the saturating hit counter.
module lmt_match_aggregator
    import lmt_match_aggregator_pkg::*;
#(
    parameter int NUM_LMTS       = 5,
    parameter int NUM_PMTS       = 32,
    parameter int PMT_DEPTH      = 32,
    parameter int PMT_ID_WIDTH   = 6,
    parameter int LMT_MAX_DEPTH  = 256,
    parameter int LMT_ADDR_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_LMTS-1:0]                  lmt_used,
    input  logic [NUM_LMTS*2-1:0]                lmt_width_gear,
    input  logic [NUM_LMTS*3-1:0]                lmt_depth_gear,
    input  logic [NUM_LMTS*PMT_ID_WIDTH-1:0]     lmt_aspid,
    input  logic [NUM_LMTS-1:0]                  lmt_search_valid,
    input  logic [NUM_PMTS*PMT_DEPTH-1:0]        pmt_matchlines,
    input  logic                                 stat_clr,
    output logic [NUM_LMTS*LMT_MAX_DEPTH-1:0]    lmt_matchlines,
    output logic [NUM_LMTS-1:0]                  lmt_match_found,
    output logic [NUM_LMTS*LMT_ADDR_WIDTH-1:0]   lmt_match_addr,
    output logic [NUM_LMTS-1:0]                  lmt_result_valid,
    output logic [NUM_LMTS-1:0]                  lmt_cfg_error,
    output logic [NUM_LMTS*16-1:0]               lmt_hit_count
);

    localparam int MAX_SEGS = LMT_MAX_DEPTH / PMT_DEPTH;

    logic [PMT_DEPTH-1:0] pmt_row [NUM_PMTS];

    for (genvar gp = 0; gp < NUM_PMTS; gp++) begin : g_pmt
        assign pmt_row[gp] = pmt_matchlines[gp*PMT_DEPTH +: PMT_DEPTH];
    end

    for (genvar gi = 0; gi < NUM_LMTS; gi++) begin : g_lmt
        logic [1:0]                wg;
        logic [2:0]                dg;
        logic [PMT_ID_WIDTH-1:0]   asp;
        int                        asp_i;
        int                        wn;
        int                        dn;
        logic                      qual_v;
        logic [PMT_DEPTH-1:0]      seg;
        logic [LMT_MAX_DEPTH-1:0]  comb_ml;
        logic                      s1_v;
        logic [LMT_MAX_DEPTH-1:0]  s1_ml;
        logic                      enc_found;
        logic [LMT_ADDR_WIDTH-1:0] enc_addr;
        logic                      res_v;
        logic [LMT_MAX_DEPTH-1:0]  ml_q;
        logic                      found_q;
        logic [LMT_ADDR_WIDTH-1:0] addr_q;
        logic [15:0]               hit_cnt;

        assign wg    = lmt_width_gear[gi*2 +: 2];
        assign dg    = lmt_depth_gear[gi*3 +: 3];
        assign asp   = lmt_aspid[gi*PMT_ID_WIDTH +: PMT_ID_WIDTH];
        assign asp_i = int'(asp);
        assign wn    = gear_wn(wg);
        assign dn    = gear_dn(dg);

        assign lmt_cfg_error[gi] = lmt_used[gi] &&
                                   ((wg == WG_BAD) || (dg > DG_MAX) ||
                                    (wn * dn > MAX_PMTS_PER_LMT) ||
                                    (asp_i + wn * dn > NUM_PMTS));

        // a broken or disabled table never launches a search
        assign qual_v = lmt_search_valid[gi] & lmt_used[gi] & ~lmt_cfg_error[gi];

        // masked-AND across width, concatenation across depth; unused rows stay 0
        always_comb begin
            comb_ml = '0;
            seg     = '1;
            for (int d = 0; d < MAX_SEGS; d++) begin
                seg = '1;
                for (int w = 0; w < 4; w++) begin
                    for (int p = 0; p < NUM_PMTS; p++) begin
                        if (w < wn && p == pmt_index(asp_i, wn, d, w)) begin
                            seg = seg & pmt_row[p];
                        end
                    end
                end
                if (d < dn) begin
                    comb_ml[d*PMT_DEPTH +: PMT_DEPTH] = seg;
                end
            end
        end

        // stage 1: geometry is sampled here, so in-flight searches keep their config
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_v  <= 1'b0;
                s1_ml <= '0;
            end else begin
                s1_v <= qual_v;
                if (qual_v) begin
                    s1_ml <= comb_ml;
                end
            end
        end

        lmt_prio_encoder #(
            .LMT_MAX_DEPTH  (LMT_MAX_DEPTH),
            .LMT_ADDR_WIDTH (LMT_ADDR_WIDTH)
        ) u_enc (
            .lines (s1_ml),
            .addr  (enc_addr),
            .found (enc_found)
        );

        // stage 2: result registers only move on a valid search
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                res_v   <= 1'b0;
                ml_q    <= '0;
                found_q <= 1'b0;
                addr_q  <= '0;
            end else begin
                res_v <= s1_v;
                if (s1_v) begin
                    ml_q    <= s1_ml;
                    found_q <= enc_found;
                    addr_q  <= enc_addr;
                end
            end
        end

        // saturating hit counter; clear wins over a same-cycle hit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hit_cnt <= '0;
            end else if (stat_clr) begin
                hit_cnt <= '0;
            end else if (s1_v && enc_found && hit_cnt != 16'hFFFF) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
        end

        assign lmt_matchlines[gi*LMT_MAX_DEPTH +: LMT_MAX_DEPTH]  = ml_q;
        assign lmt_match_found[gi]                                = found_q;
        assign lmt_match_addr[gi*LMT_ADDR_WIDTH +: LMT_ADDR_WIDTH] = addr_q;
        assign lmt_result_valid[gi]                               = res_v;
        assign lmt_hit_count[gi*16 +: 16]                         = hit_cnt;
    end

endmodule

// File: tb/tb_lmt_match_aggregator.sv
`timescale 1ns/1ps
// Scoreboard bench: stimulus pushes the expected result of each search,
// the monitor pops and compares on every result strobe.
module tb_lmt_match_aggregator;

    localparam int NL = 5;
    localparam int NP = 32;
    localparam int PD = 32;
    localparam int IW = 6;
    localparam int MD = 256;
    localparam int AW = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NL-1:0]      lmt_used;
    logic [NL*2-1:0]    lmt_width_gear;
    logic [NL*3-1:0]    lmt_depth_gear;
    logic [NL*IW-1:0]   lmt_aspid;
    logic [NL-1:0]      lmt_search_valid;
    logic [NP*PD-1:0]   pmt_matchlines;
    logic               stat_clr;
    logic [NL*MD-1:0]   lmt_matchlines;
    logic [NL-1:0]      lmt_match_found;
    logic [NL*AW-1:0]   lmt_match_addr;
    logic [NL-1:0]      lmt_result_valid;
    logic [NL-1:0]      lmt_cfg_error;
    logic [NL*16-1:0]   lmt_hit_count;

    always #5 clk = ~clk;

    lmt_match_aggregator dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .lmt_used         (lmt_used),
        .lmt_width_gear   (lmt_width_gear),
        .lmt_depth_gear   (lmt_depth_gear),
        .lmt_aspid        (lmt_aspid),
        .lmt_search_valid (lmt_search_valid),
        .pmt_matchlines   (pmt_matchlines),
        .stat_clr         (stat_clr),
        .lmt_matchlines   (lmt_matchlines),
        .lmt_match_found  (lmt_match_found),
        .lmt_match_addr   (lmt_match_addr),
        .lmt_result_valid (lmt_result_valid),
        .lmt_cfg_error    (lmt_cfg_error),
        .lmt_hit_count    (lmt_hit_count)
    );

    typedef struct {
        int lmt;
        bit found;
        int addr;
        int hits;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   mdl_hits [NL];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int i, input bit u, input logic [1:0] wg,
                           input logic [2:0] dg, input int asp);
        lmt_used[i]              = u;
        lmt_width_gear[i*2 +: 2] = wg;
        lmt_depth_gear[i*3 +: 3] = dg;
        lmt_aspid[i*IW +: IW]    = asp[IW-1:0];
    endtask

    task automatic set_row(input int p, input int r);
        pmt_matchlines[p*PD + r] = 1'b1;
    endtask

    // raise valid for LMT i this cycle and record what must come back
    task automatic push(input int i, input bit f, input int a, input bit clr_next = 1'b0);
        exp_t e;
        lmt_search_valid[i] = 1'b1;
        if (f) mdl_hits[i] = (mdl_hits[i] == 65535) ? 65535 : mdl_hits[i] + 1;
        if (clr_next) mdl_hits[i] = 0;
        e.lmt   = i;
        e.found = f;
        e.addr  = a;
        e.hits  = mdl_hits[i];
        e.cyc   = cyc + 2;
        sbq.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk(name, sbq.size(), 0);
        repeat (3) step();
    endtask

    task automatic cfg_case(input string name, input logic [1:0] wg, input logic [2:0] dg,
                            input int asp, input logic [NL-1:0] req);
        set_cfg(4, 1'b1, wg, dg, asp);
        #1;
        chk(name, lmt_cfg_error, req);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (lmt_result_valid[i]) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_strobe lmt%0d: got strobe at cycle %0d, required none", i, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    chk($sformatf("strobe_lmt lmt%0d", i), i, mon_e.lmt);
                    chk($sformatf("latency lmt%0d", i), cyc, mon_e.cyc);
                    chk($sformatf("found lmt%0d", i), lmt_match_found[i], mon_e.found);
                    chk($sformatf("addr lmt%0d", i), lmt_match_addr[i*AW +: AW], mon_e.addr);
                    chk($sformatf("hits lmt%0d", i), lmt_hit_count[i*16 +: 16], mon_e.hits);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NL; i++) mdl_hits[i] = 0;
        rst_n            = 1'b0;
        lmt_used         = '0;
        lmt_width_gear   = '0;
        lmt_depth_gear   = '0;
        lmt_aspid        = '0;
        lmt_search_valid = '0;
        pmt_matchlines   = '0;
        stat_clr         = 1'b0;
        #1;
        chk("rst_matchlines", (lmt_matchlines == '0), 1);
        chk("rst_found", lmt_match_found, 0);
        chk("rst_addr", lmt_match_addr, 0);
        chk("rst_valid", lmt_result_valid, 0);
        chk("rst_hits", lmt_hit_count, 0);
        chk("rst_cfg_error", lmt_cfg_error, 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        set_cfg(0, 1'b1, 2'b00, 3'b001, 0);
        set_cfg(1, 1'b1, 2'b01, 3'b010, 2);
        set_cfg(2, 1'b1, 2'b01, 3'b000, 31);
        set_cfg(3, 1'b1, 2'b10, 3'b001, 24);
        set_cfg(4, 1'b0, 2'b11, 3'b000, 0);
        #1;
        chk("cfg_base", lmt_cfg_error, 5'b00100);
        cfg_case("cfg_wg11", 2'b11, 3'b000, 0, 5'b10100);
        cfg_case("cfg_area16", 2'b10, 3'b010, 0, 5'b10100);
        cfg_case("cfg_dg4", 2'b00, 3'b100, 0, 5'b10100);
        cfg_case("cfg_fit_edge", 2'b00, 3'b011, 24, 5'b00100);
        cfg_case("cfg_overrun", 2'b00, 3'b011, 25, 5'b10100);
        set_cfg(4, 1'b0, 2'b00, 3'b011, 25);
        #1;
        chk("cfg_unused", lmt_cfg_error, 5'b00100);
        step();

        // LMT0 depth 2: PMT1 row 8 lands on row 40
        set_row(1, 8);
        push(0, 1, 40);
        step();
        lmt_search_valid = '0;
        drain("drain_basic");
        chk("hold_addr", lmt_match_addr[AW-1:0], 40);
        chk("hold_found", lmt_match_found[0], 1);
        chk("ml_bit40", lmt_matchlines[40], 1);
        chk("ml_bit8", lmt_matchlines[8], 0);

        // LMT1 width 2: one half alone does not match, both halves do (back to back)
        pmt_matchlines = '0;
        set_row(2, 0);
        push(1, 0, 0);
        step();
        set_row(3, 0);
        push(1, 1, 0);
        step();
        lmt_search_valid = '0;
        drain("drain_width");

        // lowest segment wins
        pmt_matchlines = '0;
        set_row(4, 5); set_row(5, 5); set_row(8, 1); set_row(9, 1);
        push(1, 1, 37);
        step();
        lmt_search_valid = '0;
        drain("drain_prio");

        // misconfigured LMT2 ignores its valid
        pmt_matchlines = '0;
        set_row(31, 0);
        lmt_search_valid[2] = 1'b1;
        step();
        lmt_search_valid = '0;
        drain("drain_cfg_err");

        // all tables in the same cycle
        pmt_matchlines = '0;
        set_row(0, 2);
        set_row(6, 31); set_row(7, 31);
        set_row(24, 4); set_row(25, 4); set_row(26, 4);
        set_row(28, 4); set_row(29, 4); set_row(30, 4); set_row(31, 4);
        push(0, 1, 2);
        push(1, 1, 95);
        push(3, 1, 36);
        lmt_search_valid[2] = 1'b1;
        step();
        lmt_search_valid = '0;
        drain("drain_simul");

        // config change with a search in flight
        pmt_matchlines = '0;
        set_row(1, 8);
        push(0, 1, 40);
        step();
        set_cfg(0, 1'b1, 2'b00, 3'b001, 1);
        push(0, 1, 8);
        step();
        lmt_search_valid = '0;
        set_cfg(0, 1'b1, 2'b00, 3'b001, 0);
        drain("drain_cfg_flight");

        // three back-to-back searches
        pmt_matchlines = '0;
        set_row(0, 3);
        push(0, 1, 3);
        step();
        pmt_matchlines = '0;
        set_row(0, 0);
        push(0, 1, 0);
        step();
        pmt_matchlines = '0;
        push(0, 0, 0);
        step();
        lmt_search_valid = '0;
        drain("drain_b2b");

        // same burst, reset after the first strobe
        pmt_matchlines = '0;
        set_row(0, 3);
        push(0, 1, 3);
        step();
        pmt_matchlines = '0;
        set_row(0, 0);
        push(0, 1, 0);
        step();
        pmt_matchlines = '0;
        push(0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        chk("inflight_left", sbq.size(), 2);
        sbq.delete();
        for (int i = 0; i < NL; i++) mdl_hits[i] = 0;
        lmt_search_valid = '0;
        #1;
        chk("rst2_valid", lmt_result_valid, 0);
        chk("rst2_found", lmt_match_found, 0);
        chk("rst2_addr", lmt_match_addr, 0);
        chk("rst2_hits", lmt_hit_count, 0);
        chk("rst2_matchlines", (lmt_matchlines == '0), 1);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        drain("no_strobe_after_reset");

        // saturate LMT0: first search after reset also checks latency
        pmt_matchlines = '0;
        set_row(0, 3);
        for (int n = 0; n < 65536; n++) begin
            push(0, 1, 3);
            step();
        end
        lmt_search_valid = '0;
        drain("drain_sat");
        chk("sat_value", lmt_hit_count[15:0], 16'hFFFF);

        set_row(2, 0); set_row(3, 0);
        push(1, 1, 0);
        step();
        lmt_search_valid = '0;
        drain("drain_lmt1_hit");
        chk("lmt1_pre_clr", lmt_hit_count[31:16], 1);

        // stat_clr on the same edge as a hit
        push(0, 1, 3, 1'b1);
        push(1, 1, 0, 1'b1);
        step();
        lmt_search_valid = '0;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        drain("drain_clr");
        chk("clr_all", lmt_hit_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
